// File: rtl/riscv_32im_pkg.sv
// rtl/riscv_32im_pkg.sv - shared types and constants for the DMEM arbiter
package riscv_32im_pkg;

  // Arbiter FSM: grant in IDLE, DMEM read data lands in ACCESS, response held in RESP
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } dmem_arb_state_t;

  // Requester indices: port 0 is the LSU, port 1 is DMA/debug
  localparam logic ARB_M_LSU = 1'b0;
  localparam logic ARB_M_DMA = 1'b1;

endpackage

// File: rtl/dmem_arb_pick.sv
// rtl/dmem_arb_pick.sv - combinational grant selection (DMEM_ARB_RR_EN selects round-robin)
module dmem_arb_pick
  import riscv_32im_pkg::*;
(
  input  logic [1:0] i_valid,
  input  logic       i_rr_last,
  input  logic       i_starve_hit,
  output logic [1:0] o_grant
);

  // Only the mode-specific tie-break input is consumed; the other is parked here
  logic w_unused;

`ifdef DMEM_ARB_RR_EN
  assign w_unused = i_starve_hit;
`else
  assign w_unused = i_rr_last;
`endif

  // One-hot grant: a lone requester always wins, ties go to the mode's tie-break
  always_comb begin
    o_grant = 2'b00;
    case (i_valid)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11: begin
`ifdef DMEM_ARB_RR_EN
        o_grant = (i_rr_last == ARB_M_DMA) ? 2'b01 : 2'b10;
`else
        o_grant = i_starve_hit ? 2'b10 : 2'b01;
`endif
      end
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port arbiter for the single-port DMEM (DMEM_ARB_RR_EN selects round-robin)
module dmem_arbiter
  import riscv_32im_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_LIM = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                m0_valid_i,
  output logic                m0_ready_o,
  input  logic [ADDR_W-1:0]   m0_addr_i,
  input  logic [DATA_W-1:0]   m0_wdata_i,
  input  logic [DATA_W/8-1:0] m0_be_i,
  input  logic                m0_we_i,
  output logic                m0_rvalid_o,
  input  logic                m0_rready_i,
  output logic [DATA_W-1:0]   m0_rdata_o,
  input  logic                m1_valid_i,
  output logic                m1_ready_o,
  input  logic [ADDR_W-1:0]   m1_addr_i,
  input  logic [DATA_W-1:0]   m1_wdata_i,
  input  logic [DATA_W/8-1:0] m1_be_i,
  input  logic                m1_we_i,
  output logic                m1_rvalid_o,
  input  logic                m1_rready_i,
  output logic [DATA_W-1:0]   m1_rdata_o,
  output logic                dmem_req_o,
  output logic [ADDR_W-1:0]   dmem_addr_o,
  output logic [DATA_W-1:0]   dmem_wdata_o,
  output logic [DATA_W/8-1:0] dmem_be_o,
  output logic                dmem_we_o,
  input  logic [DATA_W-1:0]   dmem_rdata_i
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(STARVE_LIM + 1);

  dmem_arb_state_t    r_state;
  logic               r_owner;
  logic               r_we;
  logic               r_rr_last;
  logic [CNT_W-1:0]   r_starve_cnt;
  logic [DATA_W-1:0]  r_rdata_q;

  logic               w_idle;
  logic               w_resp;
  logic [1:0]         w_valid;
  logic [1:0]         w_grant;
  logic               w_gnt_any;
  logic               w_gnt_sel;
  logic               w_starve_hit;
  logic [ADDR_W-1:0]  w_addr;
  logic [DATA_W-1:0]  w_wdata;
  logic [BE_W-1:0]    w_be;
  logic               w_we;
  logic               w_owner_rready;

  // Reset gates every output so no strobe or handshake leaks out in a reset cycle
  assign w_idle       = (r_state == IDLE) && !rst_i;
  assign w_resp       = (r_state == RESP) && !rst_i;
  assign w_valid      = {m1_valid_i, m0_valid_i} & {2{w_idle}};
  assign w_starve_hit = (r_starve_cnt == CNT_W'(STARVE_LIM));

  dmem_arb_pick u_pick (
    .i_valid      (w_valid),
    .i_rr_last    (r_rr_last),
    .i_starve_hit (w_starve_hit),
    .o_grant      (w_grant)
  );

  assign w_gnt_any = |w_grant;
  assign w_gnt_sel = w_grant[1];

  assign w_addr  = w_gnt_sel ? m1_addr_i  : m0_addr_i;
  assign w_wdata = w_gnt_sel ? m1_wdata_i : m0_wdata_i;
  assign w_be    = w_gnt_sel ? m1_be_i    : m0_be_i;
  assign w_we    = w_gnt_sel ? m1_we_i    : m0_we_i;

  assign m0_ready_o = w_grant[0];
  assign m1_ready_o = w_grant[1];

  // DMEM is driven straight from the granted requester in the grant cycle; low bits forced aligned
  assign dmem_req_o   = w_gnt_any;
  assign dmem_we_o    = w_gnt_any && w_we;
  assign dmem_addr_o  = w_gnt_any ? {w_addr[ADDR_W-1:2], 2'b00} : '0;
  assign dmem_wdata_o = w_gnt_any ? w_wdata : '0;
  assign dmem_be_o    = (w_gnt_any && w_we) ? w_be : '0;

  assign m0_rvalid_o = w_resp && (r_owner == ARB_M_LSU);
  assign m1_rvalid_o = w_resp && (r_owner == ARB_M_DMA);
  assign m0_rdata_o  = m0_rvalid_o ? r_rdata_q : '0;
  assign m1_rdata_o  = m1_rvalid_o ? r_rdata_q : '0;

  assign w_owner_rready = (r_owner == ARB_M_DMA) ? m1_rready_i : m0_rready_i;

  // Transaction FSM: accept in IDLE, capture read data in ACCESS, hold response until taken
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_owner   <= ARB_M_LSU;
      r_we      <= 1'b0;
      r_rr_last <= ARB_M_DMA;
      r_rdata_q <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gnt_any) begin
            r_owner   <= w_gnt_sel;
            r_we      <= w_we;
            r_rr_last <= w_gnt_sel;
            r_state   <= ACCESS;
          end
        end
        ACCESS: begin
          r_rdata_q <= r_we ? '0 : dmem_rdata_i;
          r_state   <= RESP;
        end
        RESP: begin
          if (w_owner_rready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Port 1 wait counter: saturates at the limit, cleared whenever port 1 is granted
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_starve_cnt <= '0;
    end else if (w_grant[1]) begin
      r_starve_cnt <= '0;
    end else if (m1_valid_i && !w_starve_hit) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed scoreboard bench for dmem_arbiter
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_valid, m0_ready, m0_we, m0_rvalid, m0_rready;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [3:0]  m0_be;
  logic        m1_valid, m1_ready, m1_we, m1_rvalid, m1_rready;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m1_be;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIM(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_valid_i(m0_valid), .m0_ready_o(m0_ready), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m0_be_i(m0_be), .m0_we_i(m0_we), .m0_rvalid_o(m0_rvalid), .m0_rready_i(m0_rready),
    .m0_rdata_o(m0_rdata),
    .m1_valid_i(m1_valid), .m1_ready_o(m1_ready), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_be_i(m1_be), .m1_we_i(m1_we), .m1_rvalid_o(m1_rvalid), .m1_rready_i(m1_rready),
    .m1_rdata_o(m1_rdata),
    .dmem_req_o(dmem_req), .dmem_addr_o(dmem_addr), .dmem_wdata_o(dmem_wdata),
    .dmem_be_o(dmem_be), .dmem_we_o(dmem_we), .dmem_rdata_i(dmem_rdata)
  );

  function automatic logic [31:0] init_word(input int i);
    logic [7:0] lo;
    lo = 8'(i);
    if (i == 64) return 32'hDEADBEEF;
    return {16'hC0DE, 8'h5A, lo};
  endfunction

  // DMEM model: 1-cycle read latency, byte-enabled writes, contents reloaded on reset
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
    end else if (dmem_req) begin
      if (dmem_we) begin
        for (int b = 0; b < 4; b++)
          if (dmem_be[b]) mem[dmem_addr[9:2]][8*b +: 8] <= dmem_wdata[8*b +: 8];
      end else begin
        dmem_rdata <= mem[dmem_addr[9:2]];
      end
    end
  end

  typedef struct {
    logic        port;
    logic [31:0] data;
    int          acc;
  } exp_t;

  exp_t        sbq[$];
  logic        gq[$];
  int          total = 0;
  int          bad = 0;
  int          cyc_n = 0;
  bit          seen_rv = 0;
  logic [31:0] last_rdata;
  logic        last_port;
  int          last_rv_cyc;
  int          n0;
  logic [31:0] hold_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {20'd0, m0_ready, m1_ready, m0_rvalid, m1_rvalid, dmem_req, dmem_we,
              |dmem_addr, |dmem_wdata, |dmem_be, |m0_rdata, |m1_rdata, 1'b0}, 32'd0);
  endtask

  // Sample at the falling edge: record accepts into the scoreboard, check responses against it
  task automatic smp();
    @(negedge clk);
    if (rst) begin
      sbq.delete();
      seen_rv = 0;
    end else begin
      if (m0_valid && m0_ready) begin
        sbq.push_back('{port: 1'b0, data: (m0_we ? 32'd0 : mem[m0_addr[9:2]]), acc: cyc_n});
        gq.push_back(1'b0);
      end
      if (m1_valid && m1_ready) begin
        sbq.push_back('{port: 1'b1, data: (m1_we ? 32'd0 : mem[m1_addr[9:2]]), acc: cyc_n});
        gq.push_back(1'b1);
      end
      if (m0_rvalid || m1_rvalid) begin
        chk("rv_has_pending", 32'(sbq.size() != 0), 32'd1);
        if (sbq.size() != 0) begin
          if (!seen_rv) begin
            chk("rv_latency", cyc_n, sbq[0].acc + 2);
            chk("rv_port", {31'd0, m1_rvalid}, {31'd0, sbq[0].port});
            seen_rv = 1;
          end
          if ((m0_rvalid && m0_rready) || (m1_rvalid && m1_rready)) begin
            last_rdata  = m1_rvalid ? m1_rdata : m0_rdata;
            last_port   = m1_rvalid;
            last_rv_cyc = cyc_n;
            chk("rdata", last_rdata, sbq[0].data);
            void'(sbq.pop_front());
            seen_rv = 0;
          end
        end
      end
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (sbq.size() != 0 && k < 20) begin
      smp();
      adv();
      k++;
    end
    chk("drain_timeout", sbq.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    m0_valid = 1'b1; m0_addr = 32'h100; m0_wdata = '0; m0_be = '0; m0_we = 1'b0; m0_rready = 1'b1;
    m1_valid = 1'b1; m1_addr = 32'h20;  m1_wdata = '0; m1_be = '0; m1_we = 1'b0; m1_rready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    // Reset: requests present but nothing may come out
    smp();
    chk_all_zero("reset_outputs");
    adv();
    rst = 1'b0;
    m0_valid = 1'b0; m1_valid = 1'b0;
    smp(); adv();

    // Lone m0 read of 0x100
    m0_valid = 1'b1; m0_addr = 32'h100; m0_we = 1'b0;
    smp();
    chk("t1_m0_ready", m0_ready, 1);
    chk("t1_dmem_req", dmem_req, 1);
    chk("t1_dmem_addr", dmem_addr, 32'h100);
    chk("t1_dmem_be", dmem_be, 0);
    adv();
    m0_valid = 1'b0;
    wait_drain();
    chk("t1_rdata", last_rdata, 32'hDEADBEEF);

    // Tie: m0 write 0x10 wins, m1 read 0x20 served in the next IDLE
    m0_valid = 1'b1; m0_addr = 32'h10; m0_we = 1'b1; m0_be = 4'b0011; m0_wdata = 32'h12345678;
    m1_valid = 1'b1; m1_addr = 32'h20; m1_we = 1'b0;
    n0 = cyc_n;
    smp();
    chk("t2_m0_ready", m0_ready, 1);
    chk("t2_m1_ready", m1_ready, 0);
    chk("t2_dmem_we", dmem_we, 1);
    chk("t2_dmem_be", dmem_be, 32'h3);
    chk("t2_dmem_wdata", dmem_wdata, 32'h12345678);
    adv();
    m0_valid = 1'b0; m0_we = 1'b0; m0_be = '0;
    smp(); chk("t2_access_m1_ready", m1_ready, 0); adv();
    smp(); adv();
    smp(); chk("t2_m1_granted_n3", m1_ready, 1); chk("t2_m1_addr", dmem_addr, 32'h20); adv();
    m1_valid = 1'b0;
    wait_drain();
    chk("t2_m1_rvalid_n5", last_rv_cyc, n0 + 5);
    chk("t2_last_port", last_port, 1);
    // Read back the partially written word through m1
    m1_valid = 1'b1; m1_addr = 32'h10;
    smp(); adv();
    m1_valid = 1'b0;
    wait_drain();
    chk("t2_readback", last_rdata, {init_word(4)[31:16], 16'h5678});

    // Both requesters valid continuously for four IDLE slots
    gq.delete();
    m0_valid = 1'b1; m0_addr = 32'h40;
    m1_valid = 1'b1; m1_addr = 32'h44;
    for (int k = 0; k < 12; k++) begin
      smp();
      adv();
`ifndef DMEM_ARB_RR_EN
      if (k == 9) chk("t3_starve_cnt_clear", 32'(dut.r_starve_cnt), 0);
`endif
    end
    m0_valid = 1'b0; m1_valid = 1'b0;
    wait_drain();
    chk("t3_grant_count", gq.size(), 4);
    if (gq.size() == 4) begin
`ifdef DMEM_ARB_RR_EN
      chk("t3_g0", gq[0], 0); chk("t3_g1", gq[1], 1); chk("t3_g2", gq[2], 0); chk("t3_g3", gq[3], 1);
`else
      chk("t3_g0", gq[0], 0); chk("t3_g1", gq[1], 0); chk("t3_g2", gq[2], 0); chk("t3_g3", gq[3], 1);
`endif
    end

    // Response held while m0 withholds rready
    m0_valid = 1'b1; m0_addr = 32'h104; m0_rready = 1'b0;
    smp(); adv();
    m0_valid = 1'b0; m1_valid = 1'b1; m1_addr = 32'h48;
    smp(); adv();
    hold_data = init_word(65);
    for (int k = 0; k < 5; k++) begin
      smp();
      chk("t4_rvalid_held", m0_rvalid, 1);
      chk("t4_rdata_stable", m0_rdata, hold_data);
      chk("t4_readys_low", {m0_ready, m1_ready}, 0);
      chk("t4_no_dmem_req", dmem_req, 0);
      adv();
    end
    m1_valid = 1'b0; m0_rready = 1'b1;
    wait_drain();

    // Misaligned address, then reset during ACCESS drops the response
    m1_valid = 1'b1; m1_addr = 32'h103;
    smp();
    chk("t5_addr_aligned", dmem_addr, 32'h100);
    adv();
    m1_valid = 1'b0;
    rst = 1'b1;
    smp();
    chk_all_zero("t5_reset_in_access");
    adv();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      smp();
      chk("t5_no_rvalid", {m0_rvalid, m1_rvalid}, 0);
      adv();
    end
    m0_valid = 1'b1; m0_addr = 32'h100;
    smp();
    chk("t5_idle_after_reset", m0_ready, 1);
    adv();
    m0_valid = 1'b0;
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
